// File: rtl/core_msg_receiver.sv
// Per-core receive end of the scheduler message bus: tracks frame alignment,
// keeps this core's r0 value and instructions, and handshakes core_ready.
module core_msg_receiver #(
   parameter int CORE_ID     = 0,
   parameter int CORE_NUM    = 16,
   parameter int BUS_TO_CORE = 16,
   parameter int INSTR_SIZE  = 16,
   parameter int FRAME_SIZE  = 16,
   parameter int IBUF_DEPTH  = 256,
   localparam int AW         = $clog2(IBUF_DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   msg_valid,
   input  logic [BUS_TO_CORE-1:0] mess_to_core,
   input  logic                   exec_done,
   input  logic [AW-1:0]          instr_rd_addr,
   output logic [INSTR_SIZE-1:0]  instr_rd_data,
   output logic                   core_ready,
   output logic [INSTR_SIZE-1:0]  r0_value,
   output logic                   r0_valid,
   output logic [1:0]             fence,
   output logic [AW:0]            instr_count,
   output logic                   task_start,
   output logic                   ibuf_overflow
);

   localparam logic [3:0] LAST_W = 4'(FRAME_SIZE - 1);
   localparam logic [3:0] MY_W   = 4'(CORE_ID);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_R0, S_INSTR, S_END, S_RUN} state_t;

   state_t                state_q, state_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic [1:0]            fence_q, fence_d;
   logic [5:0]            ifn_q, ifn_d;
   logic                  sel_q, sel_d;
   logic                  r0sel_q, r0sel_d;
   logic                  r0any_q, r0any_d;
   logic [INSTR_SIZE-1:0] r0_value_q, r0_value_d;
   logic                  r0_valid_q, r0_valid_d;
   logic [AW:0]           wptr_q, wptr_d;
   logic [AW:0]           icnt_q, icnt_d;
   logic                  ovf_q, ovf_d;
   logic                  skip_act_q, skip_act_d;
   logic [6:0]            skip_cnt_q, skip_cnt_d;
   logic                  we;
   logic                  hdr_start;
   logic                  skip_start;
   logic                  busy;

   logic [INSTR_SIZE-1:0] ibuf [IBUF_DEPTH];
   logic [INSTR_SIZE-1:0] rd_q;

   // Busy = selected task handed to the executor and not yet finished.
   assign busy       = (state_q == S_RUN) || (state_q == S_END && sel_q);
   assign hdr_start  = msg_valid && !skip_act_q &&
                       ((state_q == S_IDLE) || (state_q == S_END && !sel_q));
   assign skip_start = msg_valid && busy && !skip_act_q && (wcnt_q == 4'd0);

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      fence_d    = fence_q;
      ifn_d      = ifn_q;
      sel_d      = sel_q;
      r0sel_d    = r0sel_q;
      r0any_d    = r0any_q;
      r0_value_d = r0_value_q;
      r0_valid_d = r0_valid_q;
      wptr_d     = wptr_q;
      icnt_d     = icnt_q;
      ovf_d      = ovf_q;
      skip_act_d = skip_act_q;
      skip_cnt_d = skip_cnt_q;
      we         = 1'b0;

      if (msg_valid) wcnt_d = wcnt_q + 4'd1;

      case (state_q)
         S_HDR: if (msg_valid) begin
            if (wcnt_q == 4'd1) sel_d = mess_to_core[CORE_ID];
            if (wcnt_q == 4'd2) begin
               r0sel_d = mess_to_core[CORE_ID];
               r0any_d = |mess_to_core[CORE_NUM-1:0];
            end
            if (wcnt_q == LAST_W)
               state_d = r0any_q ? S_R0 : (ifn_q != 6'd0) ? S_INSTR : S_END;
         end
         S_R0: if (msg_valid) begin
            if (wcnt_q == MY_W && r0sel_q) begin
               r0_value_d = mess_to_core[INSTR_SIZE-1:0];
               r0_valid_d = 1'b1;
            end
            if (wcnt_q == LAST_W) state_d = (ifn_q != 6'd0) ? S_INSTR : S_END;
         end
         S_INSTR: if (msg_valid) begin
            if (sel_q) begin
               if (!wptr_q[AW]) begin
                  we     = 1'b1;
                  wptr_d = wptr_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (wcnt_q == LAST_W) begin
               ifn_d = ifn_q - 6'd1;
               if (ifn_q == 6'd1) state_d = S_END;
            end
         end
         S_END: begin
            if (sel_q) begin
               icnt_d  = wptr_q;
               state_d = S_RUN;
            end else begin
               r0_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         S_RUN: if (exec_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A header seen by an unselected core in END starts the next task at once.
      if (hdr_start) begin
         fence_d    = mess_to_core[7:6];
         ifn_d      = mess_to_core[5:0];
         ovf_d      = 1'b0;
         wcnt_d     = 4'd1;
         r0_valid_d = 1'b0;
         wptr_d     = '0;
         sel_d      = 1'b0;
         r0sel_d    = 1'b0;
         r0any_d    = 1'b0;
         state_d    = S_HDR;
      end

      // Tasks whose header lands while busy are counted off frame by frame and dropped.
      if (skip_start) begin
         skip_act_d = 1'b1;
         skip_cnt_d = {1'b0, mess_to_core[5:0]};
      end else if (skip_act_q && msg_valid) begin
         if (wcnt_q == 4'd2 && (|mess_to_core[CORE_NUM-1:0])) begin
            skip_cnt_d = skip_cnt_q + 7'd1;
         end else if (wcnt_q == LAST_W) begin
            if (skip_cnt_q == 7'd0) skip_act_d = 1'b0;
            else                    skip_cnt_d = skip_cnt_q - 7'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         fence_q    <= '0;
         ifn_q      <= '0;
         sel_q      <= 1'b0;
         r0sel_q    <= 1'b0;
         r0any_q    <= 1'b0;
         r0_value_q <= '0;
         r0_valid_q <= 1'b0;
         wptr_q     <= '0;
         icnt_q     <= '0;
         ovf_q      <= 1'b0;
         skip_act_q <= 1'b0;
         skip_cnt_q <= '0;
         rd_q       <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         fence_q    <= fence_d;
         ifn_q      <= ifn_d;
         sel_q      <= sel_d;
         r0sel_q    <= r0sel_d;
         r0any_q    <= r0any_d;
         r0_value_q <= r0_value_d;
         r0_valid_q <= r0_valid_d;
         wptr_q     <= wptr_d;
         icnt_q     <= icnt_d;
         ovf_q      <= ovf_d;
         skip_act_q <= skip_act_d;
         skip_cnt_q <= skip_cnt_d;
         rd_q       <= ibuf[instr_rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (we) ibuf[wptr_q[AW-1:0]] <= mess_to_core[INSTR_SIZE-1:0];
   end

   assign instr_rd_data = rd_q;
   assign core_ready    = !busy;
   assign task_start    = (state_q == S_END) && sel_q;
   assign r0_value      = r0_value_q;
   assign r0_valid      = r0_valid_q;
   assign fence         = fence_q;
   assign instr_count   = icnt_q;
   assign ibuf_overflow = ovf_q;

endmodule

// File: tb/tb_core_msg_receiver.sv
// Directed bench for core_msg_receiver: a 256-entry and a 16-entry instance
// (both CORE_ID 3) share one message stream.
module tb_core_msg_receiver;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        msg_valid = 1'b0;
   logic [15:0] mess_to_core = '0;
   logic        exec_done = 1'b0;
   logic [7:0]  rd_addr = '0;
   logic [3:0]  rd_addr16 = '0;
   logic        gap_mode = 1'b0;

   logic [15:0] rd_data, r0_value, rd_data16, r0_value16;
   logic        core_ready, r0_valid, task_start, ovf;
   logic        core_ready16, r0_valid16, task_start16, ovf16;
   logic [1:0]  fence, fence16;
   logic [8:0]  instr_count;
   logic [4:0]  instr_count16;

   int checks = 0;
   int errors = 0;
   int ts_count = 0;
   bit ready_low_seen = 1'b0;

   always #5 clk = ~clk;

   core_msg_receiver #(.CORE_ID(3), .IBUF_DEPTH(256)) dut (
      .clk(clk), .reset(reset), .msg_valid(msg_valid), .mess_to_core(mess_to_core),
      .exec_done(exec_done), .instr_rd_addr(rd_addr), .instr_rd_data(rd_data),
      .core_ready(core_ready), .r0_value(r0_value), .r0_valid(r0_valid), .fence(fence),
      .instr_count(instr_count), .task_start(task_start), .ibuf_overflow(ovf));

   core_msg_receiver #(.CORE_ID(3), .IBUF_DEPTH(16)) dut16 (
      .clk(clk), .reset(reset), .msg_valid(msg_valid), .mess_to_core(mess_to_core),
      .exec_done(exec_done), .instr_rd_addr(rd_addr16), .instr_rd_data(rd_data16),
      .core_ready(core_ready16), .r0_value(r0_value16), .r0_valid(r0_valid16), .fence(fence16),
      .instr_count(instr_count16), .task_start(task_start16), .ibuf_overflow(ovf16));

   always @(negedge clk) begin
      if (task_start) ts_count++;
      if (!core_ready) ready_low_seen = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] w, input bit last);
      msg_valid    = 1'b1;
      mess_to_core = w;
      tick();
      msg_valid = 1'b0;
      if (gap_mode && !last) tick();
   endtask

   task automatic send_task(input logic [1:0] fe, input logic [5:0] ifn, input logic [15:0] cmask,
                            input logic [15:0] r0mask, input logic [15:0] r0v, input logic [15:0] base);
      int r0f;
      int n;
      logic [15:0] w;
      r0f = (r0mask != 16'h0) ? 1 : 0;
      n   = 16 * (1 + r0f + int'(ifn));
      for (int i = 0; i < n; i++) begin
         if (i < 16) begin
            case (i)
               0:       w = {8'h00, fe, ifn};
               1:       w = cmask;
               2:       w = r0mask;
               default: w = 16'hA5A5;
            endcase
         end else if (r0f == 1 && i < 32) begin
            w = (i == 19) ? r0v : 16'(16'h1000 + i - 16);
         end else begin
            w = 16'(base + i - 16 * (1 + r0f));
         end
         send_word(w, i == n - 1);
      end
   endtask

   task automatic finish_exec();
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      checks++; if (core_ready !== 1'b1) begin errors++; $display("FAIL ready_after_exec: got %b want 1", core_ready); end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      checks++; if (core_ready !== 1'b1) begin errors++; $display("FAIL rst_core_ready: got %b want 1", core_ready); end
      checks++; if (task_start !== 1'b0) begin errors++; $display("FAIL rst_task_start: got %b want 0", task_start); end
      checks++; if (r0_valid !== 1'b0) begin errors++; $display("FAIL rst_r0_valid: got %b want 0", r0_valid); end
      checks++; if (r0_value !== 16'h0) begin errors++; $display("FAIL rst_r0_value: got %h want 0000", r0_value); end
      checks++; if (fence !== 2'd0) begin errors++; $display("FAIL rst_fence: got %0d want 0", fence); end
      checks++; if (instr_count !== 9'd0) begin errors++; $display("FAIL rst_instr_count: got %0d want 0", instr_count); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", ovf); end
      checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data: got %h want 0000", rd_data); end
      reset = 1'b1;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_basic();
      send_task(2'd0, 6'd2, 16'h0008, 16'h0000, 16'h0000, 16'h0100);
      checks++; if (task_start !== 1'b1) begin errors++; $display("FAIL basic_task_start: got %b want 1", task_start); end
      checks++; if (core_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_fall: got %b want 0", core_ready); end
      rd_addr = 8'd17;
      tick();
      checks++; if (task_start !== 1'b0) begin errors++; $display("FAIL basic_ts_pulse: got %b want 0", task_start); end
      checks++; if (instr_count !== 9'd32) begin errors++; $display("FAIL basic_instr_count: got %0d want 32", instr_count); end
      checks++; if (rd_data !== 16'h0111) begin errors++; $display("FAIL basic_rd17: got %h want 0111", rd_data); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b want 0", ovf); end
      rd_addr = 8'd31;
      tick(); tick();
      checks++; if (rd_data !== 16'h011F) begin errors++; $display("FAIL basic_rd31: got %h want 011f", rd_data); end
      checks++; if (core_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_run: got %b want 0", core_ready); end
      finish_exec();
      $display("test_basic done");
   endtask

   task automatic test_r0();
      send_task(2'd2, 6'd1, 16'h0008, 16'h0008, 16'hBEEF, 16'h0200);
      checks++; if (task_start !== 1'b1) begin errors++; $display("FAIL r0_task_start: got %b want 1", task_start); end
      checks++; if (r0_value !== 16'hBEEF) begin errors++; $display("FAIL r0_value: got %h want beef", r0_value); end
      checks++; if (r0_valid !== 1'b1) begin errors++; $display("FAIL r0_valid: got %b want 1", r0_valid); end
      checks++; if (fence !== 2'd2) begin errors++; $display("FAIL r0_fence: got %0d want 2", fence); end
      rd_addr = 8'd5;
      tick();
      checks++; if (instr_count !== 9'd16) begin errors++; $display("FAIL r0_instr_count: got %0d want 16", instr_count); end
      checks++; if (rd_data !== 16'h0205) begin errors++; $display("FAIL r0_rd5: got %h want 0205", rd_data); end
      finish_exec();
      $display("test_r0 done");
   endtask

   task automatic test_unselected();
      int ts_before;
      ts_before      = ts_count;
      ready_low_seen = 1'b0;
      send_task(2'd1, 6'd1, 16'h0001, 16'h0001, 16'h7777, 16'h0900);
      tick();
      checks++; if (ts_count !== ts_before) begin errors++; $display("FAIL unsel_no_start: got %0d pulses want 0", ts_count - ts_before); end
      checks++; if (ready_low_seen !== 1'b0) begin errors++; $display("FAIL unsel_ready: got low want always 1"); end
      checks++; if (instr_count !== 9'd16) begin errors++; $display("FAIL unsel_instr_count: got %0d want 16", instr_count); end
      checks++; if (r0_valid !== 1'b0) begin errors++; $display("FAIL unsel_r0_valid: got %b want 0", r0_valid); end
      checks++; if (r0_value !== 16'hBEEF) begin errors++; $display("FAIL unsel_r0_value: got %h want beef", r0_value); end
      send_task(2'd1, 6'd0, 16'h0008, 16'h0000, 16'h0000, 16'h0000);
      checks++; if (task_start !== 1'b1) begin errors++; $display("FAIL next_task_start: got %b want 1", task_start); end
      tick();
      checks++; if (instr_count !== 9'd0) begin errors++; $display("FAIL next_instr_count: got %0d want 0", instr_count); end
      checks++; if (fence !== 2'd1) begin errors++; $display("FAIL next_fence: got %0d want 1", fence); end
      finish_exec();
      $display("test_unselected done");
   endtask

   task automatic test_overflow();
      send_task(2'd0, 6'd2, 16'h0008, 16'h0000, 16'h0000, 16'h0300);
      checks++; if (ovf16 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf16); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_big_flag: got %b want 0", ovf); end
      rd_addr16 = 4'd15;
      tick();
      checks++; if (instr_count16 !== 5'd16) begin errors++; $display("FAIL ovf_instr_count: got %0d want 16", instr_count16); end
      checks++; if (instr_count !== 9'd32) begin errors++; $display("FAIL ovf_big_count: got %0d want 32", instr_count); end
      checks++; if (rd_data16 !== 16'h030F) begin errors++; $display("FAIL ovf_rd15: got %h want 030f", rd_data16); end
      finish_exec();
      send_word(16'h0000, 1'b0);
      checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf16); end
      for (int i = 1; i < 16; i++) send_word((i == 1) ? 16'h0001 : 16'h0000, i == 15);
      tick();
      $display("test_overflow done");
   endtask

   task automatic test_back_to_back_gap();
      int ts_before;
      ts_before = ts_count;
      gap_mode  = 1'b1;
      send_task(2'd0, 6'd2, 16'h0008, 16'h0000, 16'h0000, 16'h0400);
      gap_mode = 1'b0;
      checks++; if (task_start !== 1'b1) begin errors++; $display("FAIL gap_task_start: got %b want 1", task_start); end
      rd_addr = 8'd31;
      tick();
      checks++; if (instr_count !== 9'd32) begin errors++; $display("FAIL gap_instr_count: got %0d want 32", instr_count); end
      checks++; if (rd_data !== 16'h041F) begin errors++; $display("FAIL gap_rd31: got %h want 041f", rd_data); end
      checks++; if (ts_count - ts_before !== 1) begin errors++; $display("FAIL gap_pulses: got %0d want 1", ts_count - ts_before); end
      finish_exec();
      $display("test_back_to_back_gap done");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 16; i++) send_word((i == 0) ? 16'h0001 : (i == 1) ? 16'h0008 : 16'h0000, 1'b0);
      for (int i = 0; i < 7; i++) send_word(16'(16'h0500 + i), 1'b0);
      reset = 1'b0;
      tick();
      checks++; if (instr_count !== 9'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", instr_count); end
      checks++; if (core_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", core_ready); end
      reset = 1'b1;
      tick();
      send_task(2'd0, 6'd1, 16'h0008, 16'h0000, 16'h0000, 16'h0600);
      checks++; if (task_start !== 1'b1) begin errors++; $display("FAIL mid_task_start: got %b want 1", task_start); end
      rd_addr = 8'd6;
      tick();
      checks++; if (instr_count !== 9'd16) begin errors++; $display("FAIL mid_instr_count: got %0d want 16", instr_count); end
      checks++; if (rd_data !== 16'h0606) begin errors++; $display("FAIL mid_rd6: got %h want 0606", rd_data); end
      finish_exec();
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_r0();
      test_unselected();
      test_overflow();
      test_back_to_back_gap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_msg_receiver.md
# core_msg_receiver

Per-core receive end of the scheduler-to-core message bus. Consumes the 16-bit word stream the scheduler broadcasts to all cores. The stream is a header frame, an optional r0 frame and `if_num` instruction frames. The block keeps only the r0 value and instructions addressed to its own `CORE_ID`, stores them for the core's executor, and drives this core's `core_ready` bit back to the scheduler. One instance sits in front of each core.

## Interface
- `CORE_ID`, 0: index of this core; selects the bit of the masks and the r0 frame word.
- `CORE_NUM`, 16: cores on the bus; mask width.
- `BUS_TO_CORE`, 16: message word width.
- `INSTR_SIZE`, 16: instruction width.
- `FRAME_SIZE`, 16: words per frame.
- `IBUF_DEPTH`, 256: instruction buffer entries; must be a power of two.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `msg_valid` in 1: `mess_to_core` carries a new word this cycle.
- `mess_to_core` in `BUS_TO_CORE`: message word.
- `exec_done` in 1: one-cycle pulse from the executor when the current task has finished.
- `instr_rd_addr` in log2(`IBUF_DEPTH`): executor read address.
- `instr_rd_data` out `INSTR_SIZE`: registered read data, one cycle after the address.
- `core_ready` out 1: core can accept a task; this is the scheduler's `core_ready[CORE_ID]`.
- `r0_value` out `INSTR_SIZE`: captured r0 init value.
- `r0_valid` out 1: `r0_value` was loaded for the current task.
- `fence` out 2: fence field of the current task.
- `instr_count` out log2(`IBUF_DEPTH`)+1: number of instructions stored.
- `task_start` out 1: one-cycle pulse, task fully received and selected.
- `ibuf_overflow` out 1: sticky flag, instructions dropped; cleared at the next header.

## Operation
Frame format:
- Header word 0: [7:6] = fence, [5:0] = `if_num`.
- Header word 1: core mask.
- Header word 2: r0 mask.
- Header words 3–15: ignored.
- r0 frame: present only if the r0 mask is nonzero; word k is the r0 value for core k.
- Instruction frames: `if_num` frames, 16 instructions each, broadcast to all cores.

Word counter `wcnt` (4 bits) advances only on `msg_valid` and wraps from 15 to 0.

FSM states:
- IDLE
  - On `msg_valid`: latch fence and `if_num`, clear `ibuf_overflow`, `wcnt` = 1, go to HDR.
- HDR
  - At word 1, latch `sel` = core_mask[`CORE_ID`].
  - At word 2, latch `r0sel` = r0_mask[`CORE_ID`] and `r0any` = (r0_mask != 0).
  - At word 15, go to R0 if `r0any`; else INSTR if `if_num` != 0; else END.
- R0
  - At word index == `CORE_ID` with `r0sel`: `r0_value` <= word and `r0_valid` <= 1.
  - At word 15, go to INSTR if `if_num` != 0, else END.
- INSTR
  - With `sel` set, each word is written to `ibuf[wptr]`, then `wptr`++.
  - When `wptr` == `IBUF_DEPTH`, further words are dropped and `ibuf_overflow` is set.
  - At word 15, decrement the frame counter; when it reaches 0, go to END.
- END (1 cycle)
  - If `sel`: pulse `task_start` and go to RUN.
  - Else go to IDLE. Stored data of an unselected core is discarded: `instr_count` and `r0_valid` are not updated.
- RUN
  - Wait for `exec_done`, then go to IDLE.

Other rules:
- `core_ready` = (state == IDLE) or (state is not RUN and `sel_prev_done`). In short: deasserted from END with `sel` until the cycle after `exec_done`. Unselected cores stay ready throughout reception; words are still tracked to keep frame alignment.
- At each header, `r0_valid` <= 0 and `wptr` <= 0.
- `instr_count` <= `wptr` at END when `sel`.
- Words arriving during RUN are ignored. The scheduler never addresses a non-ready core. Alignment rule: a header received in RUN is dropped along with its entire task.
- `exec_done` outside RUN is ignored.

## Timing
- Reset values:
  - outputs: `core_ready` = 1, `task_start` = 0, `r0_valid` = 0, `r0_value` = 0, `fence` = 0, `instr_count` = 0, `ibuf_overflow` = 0, `instr_rd_data` = 0;
  - state: IDLE, `wcnt` = 0.
- Reset mid-frame aborts the task immediately; the next `msg_valid` word is treated as a header.
- `task_start` is asserted the cycle after the last instruction word is accepted, or after the last r0/header word when `if_num` = 0.
- `core_ready` falls in the same cycle `task_start` is asserted. It rises 1 cycle after `exec_done`.
- A `msg_valid` gap of any length does not change state.
- `r0_value` is visible 1 cycle after its word.
- Buffer: single write port, single read port, 1-cycle registered read. A read of an address written in the same cycle returns the old data.

## Test plan
- `CORE_ID` = 3, header 0x0002, core mask 0x0008, r0 mask 0 → 32 instructions stored, `instr_count` = 32, `task_start` 1 cycle after word 47, `core_ready` = 0 until `exec_done`.
- `CORE_ID` = 3, r0 mask 0x0008, r0 frame word 3 = 0xBEEF, `if_num` = 1 → `r0_value` = 0xBEEF, `r0_valid` = 1, 16 instructions.
- Core mask 0x0001 with `CORE_ID` = 3 → no `task_start`, `core_ready` stays 1, state IDLE after the last word; the next header is decoded correctly.
- `IBUF_DEPTH` = 16, `if_num` = 2 → `instr_count` = 16, `ibuf_overflow` = 1; the next header clears it.
- `msg_valid` toggling 1/0 every cycle across a full task → results identical to the continuous-stream case.
- Reset asserted at INSTR word 7, then a fresh 1-frame task → only the new task is stored, `instr_count` = 16.
